// File: rtl/button_debounce.sv
// Four-channel key debouncer: 2-flop synchroniser, stable-time counter, registered level/press/release.
// Define BUTTON_DEBOUNCE_REPEAT_EN to add per-channel auto-repeat of btn_press while a key is held.
module button_debounce #(
  parameter int unsigned STABLE_CYCLES = 270000,
  parameter int unsigned REPEAT_DELAY  = 13500000,
  parameter int unsigned REPEAT_PERIOD = 2700000
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic [3:0] btn_raw_n,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_release
);

  localparam int unsigned CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    level_q, level_d;
  logic [3:0]    press_q, press_d;
  logic [3:0]    release_q, release_d;
  logic [CW-1:0] cnt_q [4];
  logic [CW-1:0] cnt_d [4];
  logic [3:0]    sync_w, diff_w, accept_w;

  assign sync_w = ~sync2_q;
  assign diff_w = sync_w ^ level_q;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCW  = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam logic [RCW-1:0] DELAY_MAX  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_MAX = RCW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  rpt_state_t     rpt_q [4];
  rpt_state_t     rpt_d [4];
  logic [RCW-1:0] rcnt_q [4];
  logic [RCW-1:0] rcnt_d [4];
`endif

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    accept_w  = '0;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i]    = cnt_q[i];
      accept_w[i] = diff_w[i] && (cnt_q[i] == CNT_MAX);
      // A bounce back to the accepted level restarts the stable-time measurement.
      if (!diff_w[i] || accept_w[i]) cnt_d[i] = '0;
      else                           cnt_d[i] = cnt_q[i] + CW'(1);
      if (accept_w[i]) begin
        level_d[i]   = ~level_q[i];
        press_d[i]   = ~level_q[i];
        release_d[i] =  level_q[i];
      end
    end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    for (int i = 0; i < 4; i++) begin
      rpt_d[i]  = rpt_q[i];
      rcnt_d[i] = rcnt_q[i];
      if (accept_w[i] && !level_q[i]) begin
        rpt_d[i]  = RPT_DELAY;
        rcnt_d[i] = '0;
      end else if (accept_w[i] && level_q[i]) begin
        // Release wins: the machine idles this cycle and no repeat pulse can join btn_release.
        rpt_d[i]  = RPT_IDLE;
        rcnt_d[i] = '0;
      end else begin
        case (rpt_q[i])
          RPT_DELAY: begin
            if (rcnt_q[i] == DELAY_MAX) begin
              press_d[i] = 1'b1;
              rpt_d[i]   = RPT_REPEAT;
              rcnt_d[i]  = '0;
            end else begin
              rcnt_d[i]  = rcnt_q[i] + RCW'(1);
            end
          end
          RPT_REPEAT: begin
            if (rcnt_q[i] == PERIOD_MAX) begin
              press_d[i] = 1'b1;
              rcnt_d[i]  = '0;
            end else begin
              rcnt_d[i]  = rcnt_q[i] + RCW'(1);
            end
          end
          default: begin
            rpt_d[i]  = RPT_IDLE;
            rcnt_d[i] = '0;
          end
        endcase
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments; synchroniser resets to "released" (raw high).
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= '0;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        rpt_q[i]  <= RPT_IDLE;
        rcnt_q[i] <= '0;
`endif
      end
    end else begin
      sync1_q   <= btn_raw_n;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= cnt_d[i];
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
        rpt_q[i]  <= rpt_d[i];
        rcnt_q[i] <= rcnt_d[i];
`endif
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
// Repeat expectations follow BUTTON_DEBOUNCE_REPEAT_EN when it is defined for the build.
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       Clock = 1'b0;
  logic       Reset_n = 1'b0;
  logic [3:0] btn_raw_n = 4'hF;
  logic [3:0] btn_level, btn_press, btn_release;

  int checks = 0;
  int failures = 0;

  button_debounce #(
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .btn_raw_n  (btn_raw_n),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 Clock = ~Clock;

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    btn_raw_n = 4'hF;
    Reset_n   = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      failures++;
      $display("FAIL reset_async got=%h exp=000", {btn_level, btn_press, btn_release});
    end
    repeat (3) tick();
    checks++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      failures++;
      $display("FAIL reset_held got=%h exp=000", {btn_level, btn_press, btn_release});
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
        failures++;
        $display("FAIL reset_exit k=%0d got=%h exp=000", k, {btn_level, btn_press, btn_release});
      end
    end
  endtask

  // Channel 0 press then release, one check set per cycle.
  task automatic test_clean_press_release();
    logic [3:0] el, ep, er;
    btn_raw_n[0] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k >= 6) ? 4'b0001 : 4'b0000;
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      er = 4'b0000;
      checks += 3;
      if (btn_level !== el) begin
        failures++; $display("FAIL press0_level k=%0d got=%b exp=%b", k, btn_level, el);
      end
      if (btn_press !== ep) begin
        failures++; $display("FAIL press0_pulse k=%0d got=%b exp=%b", k, btn_press, ep);
      end
      if (btn_release !== er) begin
        failures++; $display("FAIL press0_rel k=%0d got=%b exp=%b", k, btn_release, er);
      end
    end
    btn_raw_n[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k < 6) ? 4'b0001 : 4'b0000;
      ep = 4'b0000;
      er = (k == 6) ? 4'b0001 : 4'b0000;
      checks += 3;
      if (btn_level !== el) begin
        failures++; $display("FAIL rel0_level k=%0d got=%b exp=%b", k, btn_level, el);
      end
      if (btn_press !== ep) begin
        failures++; $display("FAIL rel0_pulse k=%0d got=%b exp=%b", k, btn_press, ep);
      end
      if (btn_release !== er) begin
        failures++; $display("FAIL rel0_rel k=%0d got=%b exp=%b", k, btn_release, er);
      end
    end
  endtask

  // Channel 1: low 3 cycles, high 1, then low held; acceptance 6 cycles after the last edge.
  task automatic test_bounce();
    logic [3:0] el, ep;
    btn_raw_n[1] = 1'b0;
    repeat (3) tick();
    btn_raw_n[1] = 1'b1;
    tick();
    btn_raw_n[1] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k >= 6) ? 4'b0010 : 4'b0000;
      ep = (k == 6) ? 4'b0010 : 4'b0000;
      checks += 2;
      if (btn_level !== el) begin
        failures++; $display("FAIL bounce_level k=%0d got=%b exp=%b", k, btn_level, el);
      end
      if (btn_press !== ep) begin
        failures++; $display("FAIL bounce_pulse k=%0d got=%b exp=%b", k, btn_press, ep);
      end
    end
    btn_raw_n[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (btn_release !== ((k == 6) ? 4'b0010 : 4'b0000)) begin
        failures++; $display("FAIL bounce_rel k=%0d got=%b", k, btn_release);
      end
    end
  endtask

  // Channel 3 accepted, channel 2 at count 3 when reset hits; both held through reset.
  task automatic test_reset_mid();
    btn_raw_n[3] = 1'b0;
    repeat (8) tick();
    checks++;
    if (btn_level !== 4'b1000) begin
      failures++; $display("FAIL midrst_pre got=%b exp=1000", btn_level);
    end
    btn_raw_n[2] = 1'b0;
    repeat (5) tick();
    #2;
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({btn_level, btn_press, btn_release} !== 12'h000) begin
      failures++;
      $display("FAIL midrst_async got=%h exp=000", {btn_level, btn_press, btn_release});
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++;
      if ({btn_level, btn_press, btn_release} !== 12'h000) begin
        failures++;
        $display("FAIL midrst_hold k=%0d got=%h exp=000", k, {btn_level, btn_press, btn_release});
      end
    end
    @(negedge Clock);
    Reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks += 3;
      if (btn_level !== ((k >= 6) ? 4'b1100 : 4'b0000)) begin
        failures++; $display("FAIL midrst_level k=%0d got=%b", k, btn_level);
      end
      if (btn_press !== ((k == 6) ? 4'b1100 : 4'b0000)) begin
        failures++; $display("FAIL midrst_pulse k=%0d got=%b", k, btn_press);
      end
      if (btn_release !== 4'b0000) begin
        failures++; $display("FAIL midrst_rel k=%0d got=%b exp=0000", k, btn_release);
      end
    end
    btn_raw_n = 4'hF;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (btn_release !== ((k == 6) ? 4'b1100 : 4'b0000)) begin
        failures++; $display("FAIL midrst_relpulse k=%0d got=%b", k, btn_release);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn_raw_n = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks += 2;
      if (btn_press !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
        failures++; $display("FAIL simul_pulse k=%0d got=%b", k, btn_press);
      end
      if (btn_level !== ((k >= 6) ? 4'b1111 : 4'b0000)) begin
        failures++; $display("FAIL simul_level k=%0d got=%b", k, btn_level);
      end
    end
    btn_raw_n = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks += 2;
      if (btn_release !== ((k == 6) ? 4'b1111 : 4'b0000)) begin
        failures++; $display("FAIL simul_rel k=%0d got=%b", k, btn_release);
      end
      if (btn_press & btn_release) begin
        failures++; $display("FAIL simul_overlap k=%0d got=%b exp=0000", k, btn_press & btn_release);
      end
    end
  endtask

  // Channel 0 held 30 cycles past acceptance; repeats at +10, +13, ... while still held.
  task automatic test_repeat();
    logic [3:0] ep;
    btn_raw_n[0] = 1'b0;
    repeat (6) tick();
    checks++;
    if (btn_press !== 4'b0001) begin
      failures++; $display("FAIL rpt_first got=%b exp=0001", btn_press);
    end
    for (int j = 1; j <= 30; j++) begin
      tick();
      ep = (REP && j >= 10 && ((j - 10) % 3 == 0)) ? 4'b0001 : 4'b0000;
      checks++;
      if (btn_press !== ep) begin
        failures++; $display("FAIL rpt_pulse j=%0d got=%b exp=%b", j, btn_press, ep);
      end
    end
    btn_raw_n[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      ep = (REP && k < 6 && ((30 + k - 10) % 3 == 0)) ? 4'b0001 : 4'b0000;
      checks += 2;
      if (btn_press !== ep) begin
        failures++; $display("FAIL rpt_tail k=%0d got=%b exp=%b", k, btn_press, ep);
      end
      if (btn_release !== ((k == 6) ? 4'b0001 : 4'b0000)) begin
        failures++; $display("FAIL rpt_rel k=%0d got=%b", k, btn_release);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press_release();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
    test_repeat();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 270000, cycles an input must hold a new value before it is accepted (10 ms at 27 MHz).
REQ-002 SHALL have parameter REPEAT_DELAY, default 13500000, cycles from accepted press to first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 2700000, cycles between subsequent auto-repeat pulses.
REQ-004 Clock  input  1  single system clock; all state rising-edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 btn_raw_n  input  4  raw board keys S1..S4, active-low, asynchronous to Clock.
REQ-007 btn_level  output  4  debounced key state, 1 = pressed.
REQ-008 btn_press  output  4  one-cycle pulse per accepted press (and per repeat when enabled).
REQ-009 btn_release  output  4  one-cycle pulse per accepted release.

Function
REQ-010 Each of the 4 channels SHALL be independent and identical; no channel SHALL affect another.
REQ-011 Each raw input SHALL pass through a 2-flop synchroniser, then be inverted to active-high (sync value).
REQ-012 Per channel, a counter wide enough for STABLE_CYCLES-1 SHALL clear whenever sync equals btn_level, and increment whenever they differ.
REQ-013 When sync differs from btn_level and the counter equals STABLE_CYCLES-1, btn_level SHALL toggle on that edge and the counter SHALL clear.
REQ-014 Latency: a clean raw edge held steady SHALL change btn_level exactly 2+STABLE_CYCLES cycles after the raw edge is sampled.
REQ-015 Any bounce returning sync to btn_level before acceptance SHALL clear the counter; the stable-time measurement restarts from zero.
REQ-016 btn_press SHALL be high exactly in the first cycle btn_level is 1 after being 0; btn_release exactly in the first cycle btn_level is 0 after being 1.
REQ-017 btn_press and btn_release SHALL never be high on the same channel in the same cycle.
REQ-018 Outputs SHALL be driven directly from flops (no combinational path from btn_raw_n).
REQ-019 Simultaneous presses on several channels SHALL produce simultaneous pulses on each.

Reset
REQ-020 Reset_n low SHALL immediately force: synchroniser flops to released (raw=1), counters 0, btn_level 0, btn_press 0, btn_release 0, repeat state idle.
REQ-021 Reset asserted mid-debounce SHALL discard the partial count; no pulse SHALL be emitted during or on exit from reset.
REQ-022 A key held across reset deassertion SHALL be treated as a new press: btn_press after 2+STABLE_CYCLES cycles.

Configuration
REQ-023 Macro BUTTON_DEBOUNCE_REPEAT_EN SHALL compile in auto-repeat; when undefined, btn_press fires once per press and REPEAT_* are unused.
REQ-024 With BUTTON_DEBOUNCE_REPEAT_EN, each channel SHALL have a repeat state machine: IDLE -> DELAY on accepted press; DELAY -> REPEAT after REPEAT_DELAY cycles with btn_press pulse; REPEAT pulses btn_press every REPEAT_PERIOD cycles.
REQ-025 Accepted release or reset SHALL return the repeat machine to IDLE in the same cycle; no repeat pulse SHALL coincide with btn_release.
REQ-026 btn_level and btn_release behaviour SHALL be identical with and without the macro.

Verification (bench parameters STABLE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-027 Clean press: btn_raw_n[0] 1->0 held -> btn_level[0]=1 and one btn_press[0] pulse 6 cycles after the edge; other channels stay 0.
REQ-028 Bounce: raw[1] low 3 cycles, high 1, low held -> no pulse until 4 consecutive stable sync cycles; exactly one btn_press[1].
REQ-029 Release: key held then raw 0->1 held -> btn_level 0 and one btn_release pulse 6 cycles later; no btn_press.
REQ-030 Reset mid-operation: Reset_n low 2 cycles at count 3 of a press -> all outputs 0 immediately, no pulse; key still held -> press 6 cycles after Reset_n rises.
REQ-031 Simultaneous: raw = 4'b0000 at one edge -> btn_press = 4'b1111 for one cycle.
REQ-032 Repeat (macro defined): key held 30 cycles after acceptance -> btn_press at +0, +10, +13, +16, ..., +28; without macro only at +0.
